// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
//
// Purpose:
//   Control FSM for the 4-bit calculator datapath (regA, regB, ALU, regC and
//   the hex displays). One operation runs through these states:
//     LOAD_A -> LOAD_B -> EXEC (EXEC_CYCLES cycles) -> STORE -> DONE.
//   - LOAD_A and LOAD_B each issue a one-cycle load strobe for regA or regB,
//     which capture the shared Dados bus.
//   - LOAD_B also latches the operation select from Instrucao.
//   - EXEC holds the ALU for EXEC_CYCLES cycles.
//   - STORE writes regC.
//   - DONE pulses fim for one cycle.
//   The current state code is exported for the state debug display.
//
// Parameters:
//   EXEC_CYCLES : number of cycles spent in EXEC (1..15).
//   CNT_W       : width of the EXEC down-counter; must hold EXEC_CYCLES-1.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst        in   asynchronous active-high reset
//   inicio     in   start request (level), sampled in IDLE and DONE
//   aborta     in   synchronous abort, forces IDLE from any state
//   Instrucao  in   operation select, sampled only in LOAD_B
//   ld_a       out  regA load strobe
//   ld_b       out  regB load strobe
//   ld_c       out  regC (result) write strobe
//   op_sel     out  ALU operation select (valid in EXEC and STORE)
//   state      out  current state code (4 bits)
//   fim        out  operation-complete pulse
//   op_count   out  completed-operation counter, 8 bits, wraps at 255.
//                   Present only when CALC_SEQ_OPCOUNT_EN is defined.
//
// Optional feature macro: CALC_SEQ_OPCOUNT_EN
//
// All outputs are decoded from registered state only. No input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module calc_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       inicio,
  input  logic       aborta,
  input  logic       Instrucao,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_c,
  output logic       op_sel,
  output logic [3:0] state,
  output logic       fim
`ifdef CALC_SEQ_OPCOUNT_EN
  ,
  output logic [7:0] op_count
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_EXEC   = 4'd3,
    S_STORE  = 4'd4,
    S_DONE   = 4'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_op;
  logic             w_op_next;

  // State register, EXEC counter and latched operation select.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_c         = 1'b0;
    op_sel       = 1'b0;
    fim          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (inicio) w_state_next = S_LOAD_A;
      end

      S_LOAD_A: begin
        ld_a         = 1'b1;
        w_state_next = S_LOAD_B;
      end

      S_LOAD_B: begin
        ld_b         = 1'b1;
        w_op_next    = Instrucao;
        w_cnt_next   = CNT_W'(EXEC_CYCLES - 1);
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        op_sel = r_op;
        if (r_cnt == '0) w_state_next = S_STORE;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end

      S_STORE: begin
        ld_c         = 1'b1;
        op_sel       = r_op;
        w_state_next = S_DONE;
      end

      S_DONE: begin
        fim = 1'b1;
        // A held inicio chains straight into the next operation.
        w_state_next = inicio ? S_LOAD_A : S_IDLE;
      end

      // Unused codes 6..15 recover to IDLE.
      default: w_state_next = S_IDLE;
    endcase

    // Abort overrides every transition, including a start request.
    if (aborta) w_state_next = S_IDLE;
  end

  assign state = r_state;

`ifdef CALC_SEQ_OPCOUNT_EN
  logic [7:0] r_op_count;

  // Only completed operations reach DONE, so aborted runs are never counted.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                   r_op_count <= 8'd0;
    else if (r_state == S_DONE) r_op_count <= r_op_count + 8'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule
